// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Streams a program image into a word-addressed RAM. Bytes arrive on a
// valid/ready byte stream, are packed big-endian into 32-bit words, and each
// completed word is written to the RAM in a single Enable cycle at
// consecutive addresses starting from BASE_ADDR (wrapping at 16'hFFFF).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a running XOR of every written word is kept. After the
//   last word the loader accepts a 4-byte big-endian trailer and flags
//   `error` if it differs from the running XOR. When undefined, the
//   checksum state and logic are absent and `error` is tied low.
//
// Ports
//   Clk         system clock, all state changes on the rising edge
//   Reset       asynchronous active-high reset
//   start       begin a load (only looked at while idle)
//   length      number of 32-bit words, captured with an accepted start
//   byte_in     program byte stream data
//   byte_valid  byte_in carries a valid byte
//   byte_ready  loader takes byte_in this cycle
//   Enable      RAM enable, high only in the write cycle
//   RW          RAM direction, 1 = read, 0 = write
//   Address     RAM word address
//   In          RAM write data
//   busy        load in progress
//   done        one-cycle pulse when the load completes
//   error       checksum mismatch, held until the next accepted start
// ---------------------------------------------------------------------------
module program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] length,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        Enable,
    output logic        RW,
    output logic [15:0] Address,
    output logic [31:0] In,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CSUM, S_DONE} state_t;
    // State entered once all data words have been written.
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] word_cnt_inc;
    logic        accept;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
    logic        error_q, error_d;
`endif

    assign accept       = byte_valid & byte_ready;
    // word_cnt_q never exceeds length-1 while writing, so this cannot overflow.
    assign word_cnt_inc = word_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        error_d    = error_q;
`endif
        byte_ready = 1'b0;
        Enable     = 1'b0;
        RW         = 1'b1;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = length;
                    addr_d     = BASE_ADDR;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 32'd0;
                    error_d    = 1'b0;
`endif
                    state_d    = (length == 16'd0) ? S_TAIL : S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready = 1'b1;
                if (accept) begin
                    // Shift left so the first byte ends up in [31:24].
                    data_d     = {data_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                Enable     = 1'b1;
                RW         = 1'b0;
                addr_d     = addr_q + 16'd1;
                word_cnt_d = word_cnt_inc;
`ifdef LOADER_CHECKSUM_EN
                csum_d     = csum_q ^ data_q;
`endif
                state_d    = (word_cnt_inc < len_q) ? S_COLLECT : S_TAIL;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                // The trailer reuses the word shift register; In is only
                // meaningful to the RAM while Enable is high.
                if (accept) begin
                    data_d     = {data_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        error_d = ({data_q[23:0], byte_in} != csum_q);
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            addr_q     <= BASE_ADDR;
            data_q     <= 32'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 32'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            error_q    <= error_d;
`endif
        end
    end

    assign Address = addr_q;
    assign In      = data_q;
    assign busy    = (state_q != S_IDLE);
`ifdef LOADER_CHECKSUM_EN
    assign error   = error_q;
`else
    assign error   = 1'b0;
`endif

endmodule
